// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
//   master : requester side (drives req/we/addr/wdata, receives ready/rvalid/rdata/err)
//   slave  : arbiter side
//   req    request, held with we/addr/wdata until ready
//   we     1 = store word, 0 = load word
//   addr   byte address
//   wdata  store data
//   ready  access accepted this cycle (combinational)
//   rvalid load data valid, one cycle after acceptance
//   rdata  load data, held until the next rvalid
//   err    one-cycle pulse after an out-of-range or misaligned access
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port word memory between the core load/store path
// and a host (test load / debug) port. At most one access is granted per cycle; the
// core normally wins, but after MAX_WAIT consecutive host losses the host is granted.
// Load data returns one cycle after acceptance. Out-of-range or misaligned accesses
// are accepted without touching memory and answered with err (and rdata=0 for loads).
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   core, host   requester ports (dmem_arbiter_if.slave)
//   mem_en       memory access strobe
//   mem_we       memory write enable, only with mem_en
//   mem_addr     memory word index
//   mem_wdata    memory write data
//   mem_rdata    memory read data, valid the cycle after a read strobe
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned MAX_WAIT = 4,
    localparam int unsigned MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     core,
    dmem_arbiter_if.slave     host,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    // ------------------------------------------------------------------
    // Address legality per port
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] core_word;
    logic [ADDR_W-1:0] host_word;
    logic              core_legal;
    logic              host_legal;

    assign core_word  = core.addr >> 2;
    assign host_word  = host.addr >> 2;
    assign core_legal = (core.addr[1:0] == 2'b00) && (core_word < ADDR_W'(DEPTH));
    assign host_legal = (host.addr[1:0] == 2'b00) && (host_word < ADDR_W'(DEPTH));

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [WAIT_W-1:0] host_wait_q;
    logic [WAIT_W-1:0] host_wait_d;
    logic              grant_core;
    logic              grant_host;

    always_comb begin
        grant_core = 1'b0;
        grant_host = 1'b0;
        if (core.req && host.req) begin
            if (host_wait_q == WAIT_W'(MAX_WAIT)) begin
                grant_host = 1'b1;
            end else begin
                grant_core = 1'b1;
            end
        end else if (core.req) begin
            grant_core = 1'b1;
        end else if (host.req) begin
            grant_host = 1'b1;
        end
    end

    // Counts host losses under contention; never exceeds MAX_WAIT because the
    // host wins as soon as the count reaches it.
    always_comb begin
        host_wait_d = host_wait_q;
        if (grant_host) begin
            host_wait_d = '0;
        end else if (core.req && host.req) begin
            host_wait_d = host_wait_q + WAIT_W'(1);
        end
    end

    assign core.ready = grant_core;
    assign host.ready = grant_host;

    // ------------------------------------------------------------------
    // Memory request mux
    // ------------------------------------------------------------------
    logic              sel_we;
    logic              sel_legal;
    logic [ADDR_W-1:0] sel_word;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        if (grant_host) begin
            sel_we    = host.we;
            sel_legal = host_legal;
            sel_word  = host_word;
            sel_wdata = host.wdata;
        end else begin
            sel_we    = core.we;
            sel_legal = core_legal;
            sel_word  = core_word;
            sel_wdata = core.wdata;
        end
    end

    // An illegal access still consumes the slot but never strobes memory.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if ((grant_core || grant_host) && sel_legal) begin
            mem_en    = 1'b1;
            mem_we    = sel_we;
            mem_addr  = sel_word[MEM_AW-1:0];
            mem_wdata = sel_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    logic core_rd_acc;
    logic host_rd_acc;

    assign core_rd_acc = grant_core && !core.we;
    assign host_rd_acc = grant_host && !host.we;

    logic              core_rvalid_q;
    logic              core_err_q;
    logic              core_rd_mem_q;   // legal core load in flight: rdata comes from memory
    logic [DATA_W-1:0] core_rdata_q;
    logic              host_rvalid_q;
    logic              host_err_q;
    logic              host_rd_mem_q;
    logic [DATA_W-1:0] host_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            host_wait_q   <= '0;
            core_rvalid_q <= 1'b0;
            core_err_q    <= 1'b0;
            core_rd_mem_q <= 1'b0;
            core_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            host_err_q    <= 1'b0;
            host_rd_mem_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            host_wait_q   <= host_wait_d;

            core_rvalid_q <= core_rd_acc;
            core_rd_mem_q <= core_rd_acc && core_legal;
            core_err_q    <= grant_core && !core_legal;
            // A new illegal load overrides capture of the load being returned now.
            if (core_rd_acc && !core_legal) begin
                core_rdata_q <= '0;
            end else if (core_rd_mem_q) begin
                core_rdata_q <= mem_rdata;
            end

            host_rvalid_q <= host_rd_acc;
            host_rd_mem_q <= host_rd_acc && host_legal;
            host_err_q    <= grant_host && !host_legal;
            if (host_rd_acc && !host_legal) begin
                host_rdata_q <= '0;
            end else if (host_rd_mem_q) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    // In the return cycle the memory output is passed straight through; afterwards
    // the captured copy holds it until the next rvalid.
    assign core.rvalid = core_rvalid_q;
    assign core.err    = core_err_q;
    assign core.rdata  = core_rd_mem_q ? mem_rdata : core_rdata_q;
    assign host.rvalid = host_rvalid_q;
    assign host.err    = host_err_q;
    assign host.rdata  = host_rd_mem_q ? mem_rdata : host_rdata_q;

endmodule
